// File: rtl/hex_dump_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hex_dump_pkg
//  Description : Shared state encoding and ASCII constants for the hex-dump
//                line transmitter and its nibble-to-ASCII helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package hex_dump_pkg;

    // Line-emission states; SP is only reachable when digit grouping is built in.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HEX  = 3'd1,
        ST_CR   = 3'd2,
        ST_LF   = 3'd3,
        ST_SP   = 3'd4
    } state_e;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_SP   = 8'h20;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_A_UC = 8'h41;
    localparam logic [7:0] ASCII_A_LC = 8'h61;

endpackage : hex_dump_pkg
`default_nettype wire

// File: rtl/hex_dump_tx_nibble_to_ascii.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_to_ascii
//  Description : Combinational 4-bit value to ASCII hex digit.
//  Ports       : i_nibble [3:0] in  - value 0..15
//                o_ascii  [7:0] out - '0'..'9', then 'A'..'F' or 'a'..'f'
//  Parameters  : UPPERCASE - nonzero selects 'A'..'F', zero selects 'a'..'f'
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_to_ascii
    import hex_dump_pkg::*;
#(
    parameter int UPPERCASE = 1
) (
    input  logic [3:0] i_nibble,
    output logic [7:0] o_ascii
);

    localparam logic [7:0] ALPHA_BASE = (UPPERCASE != 0) ? ASCII_A_UC : ASCII_A_LC;

    always_comb begin
        o_ascii = ASCII_0 + {4'd0, i_nibble};
        if (i_nibble > 4'd9) begin
            o_ascii = ALPHA_BASE + {4'd0, i_nibble} - 8'd10;
        end
    end

endmodule : nibble_to_ascii
`default_nettype wire

// File: rtl/hex_dump_tx.sv
`default_nettype none
// ============================================================================
//  Module      : hex_dump_tx
//  Description : Captures a wide word and streams it to a UART as one ASCII
//                hex line: digits MSB nibble first, then CR, LF. One
//                character advances per i_tx_ready pulse.
//  Ports       : clk        in   clock, rising edge
//                RESET      in   asynchronous active-low reset
//                i_valid    in   word offered on i_word
//                i_word     in   word to dump, sampled on acceptance only
//                o_in_ready out  block idle and able to accept a word
//                o_tx_data  out  registered character for the UART
//                o_tx_valid out  o_tx_data holds a real character
//                i_tx_ready in   one-cycle pulse, UART takes o_tx_data
//                o_busy     out  line in progress
//  Parameters  : WORD_BITS (multiple of 4, >= 8), UPPERCASE, IDLE_CHAR
//  Build macro : HEX_DUMP_GROUP_EN - insert a space after every 4 digits
//                (except after the last group)
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_dump_tx
    import hex_dump_pkg::*;
#(
    parameter int         WORD_BITS = 96,
    parameter int         UPPERCASE = 1,
    parameter logic [7:0] IDLE_CHAR = 8'h00
) (
    input  logic                 clk,
    input  logic                 RESET,
    input  logic                 i_valid,
    input  logic [WORD_BITS-1:0] i_word,
    output logic                 o_in_ready,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_valid,
    input  logic                 i_tx_ready,
    output logic                 o_busy
);

    localparam int NIBBLES = WORD_BITS / 4;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;
    logic [WORD_BITS-1:0]   word_q,  word_d;
    logic [7:0]             data_q,  data_d;
    logic [3:0]             nibble;
    logic [7:0]             digit;

`ifdef HEX_DUMP_GROUP_EN
    // Digits already sent in the current group of four.
    logic [1:0]             grp_q,   grp_d;
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            data_q  <= IDLE_CHAR;
`ifdef HEX_DUMP_GROUP_EN
            grp_q   <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            data_q  <= data_d;
`ifdef HEX_DUMP_GROUP_EN
            grp_q   <= grp_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
`ifdef HEX_DUMP_GROUP_EN
        grp_d   = grp_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    state_d = ST_HEX;
                    cnt_d   = CNT_LAST;
                    word_d  = i_word;
`ifdef HEX_DUMP_GROUP_EN
                    grp_d   = 2'd0;
`endif
                end
            end
            ST_HEX: begin
                if (i_tx_ready) begin
                    if (cnt_q == '0) begin
                        state_d = ST_CR;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
`ifdef HEX_DUMP_GROUP_EN
                        // Groups count from the first digit sent, so a
                        // short leading group never occurs.
                        grp_d = grp_q + 2'd1;
                        if (grp_q == 2'd3) begin
                            state_d = ST_SP;
                        end
`endif
                    end
                end
            end
`ifdef HEX_DUMP_GROUP_EN
            ST_SP: begin
                if (i_tx_ready) begin
                    state_d = ST_HEX;
                end
            end
`endif
            ST_CR: begin
                if (i_tx_ready) begin
                    state_d = ST_LF;
                end
            end
            ST_LF: begin
                // Back to IDLE only; a waiting word is taken next cycle.
                if (i_tx_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic. The character is computed from the *next* state so
    // that o_tx_data can be a plain register that only changes on an
    // advance and shows the first digit right after acceptance.
    // ------------------------------------------------------------------
    assign nibble = word_d[{cnt_d, 2'b00} +: 4];

    nibble_to_ascii #(
        .UPPERCASE (UPPERCASE)
    ) u_nibble_to_ascii (
        .i_nibble (nibble),
        .o_ascii  (digit)
    );

    always_comb begin
        data_d = IDLE_CHAR;
        case (state_d)
            ST_HEX:  data_d = digit;
            ST_CR:   data_d = ASCII_CR;
            ST_LF:   data_d = ASCII_LF;
`ifdef HEX_DUMP_GROUP_EN
            ST_SP:   data_d = ASCII_SP;
`endif
            default: data_d = IDLE_CHAR;
        endcase
    end

    assign o_tx_data  = data_q;
    assign o_tx_valid = (state_q != ST_IDLE);
    assign o_busy     = (state_q != ST_IDLE);
    assign o_in_ready = (state_q == ST_IDLE);

endmodule : hex_dump_tx
`default_nettype wire

// File: tb/tb_hex_dump_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hex_dump_tx
//  Description : Scoreboard bench for hex_dump_tx. Stimulus pushes the
//                expected character stream per DUT instance; monitors pop
//                and compare on every character the UART model takes.
//                Instances: A (16 bit, upper), B (96 bit, upper),
//                C (32 bit, lower). Grouped output expected when the
//                HEX_DUMP_GROUP_EN macro is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_dump_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // UART model: one-cycle ready pulse every 10 cycles, shared by all DUTs.
    logic tx_ready = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tx_ready = ((cyc % 10) == 9);
        end
    end

    logic a_rst_n, bc_rst_n;

    logic        a_valid, a_in_ready, a_tx_valid, a_busy;
    logic [15:0] a_word;
    logic [7:0]  a_tx_data;
    logic        b_valid, b_in_ready, b_tx_valid, b_busy;
    logic [95:0] b_word;
    logic [7:0]  b_tx_data;
    logic        c_valid, c_in_ready, c_tx_valid, c_busy;
    logic [31:0] c_word;
    logic [7:0]  c_tx_data;

    hex_dump_tx #(.WORD_BITS(16), .UPPERCASE(1), .IDLE_CHAR(8'h00)) dut_a (
        .clk(clk), .RESET(a_rst_n), .i_valid(a_valid), .i_word(a_word),
        .o_in_ready(a_in_ready), .o_tx_data(a_tx_data), .o_tx_valid(a_tx_valid),
        .i_tx_ready(tx_ready), .o_busy(a_busy));

    hex_dump_tx #(.WORD_BITS(96), .UPPERCASE(1), .IDLE_CHAR(8'h00)) dut_b (
        .clk(clk), .RESET(bc_rst_n), .i_valid(b_valid), .i_word(b_word),
        .o_in_ready(b_in_ready), .o_tx_data(b_tx_data), .o_tx_valid(b_tx_valid),
        .i_tx_ready(tx_ready), .o_busy(b_busy));

    hex_dump_tx #(.WORD_BITS(32), .UPPERCASE(0), .IDLE_CHAR(8'h00)) dut_c (
        .clk(clk), .RESET(bc_rst_n), .i_valid(c_valid), .i_word(c_word),
        .o_in_ready(c_in_ready), .o_tx_data(c_tx_data), .o_tx_valid(c_tx_valid),
        .i_tx_ready(tx_ready), .o_busy(c_busy));

    // Stand-alone nibble converters.
    logic [3:0] nib;
    logic [7:0] nib_uc, nib_lc;
    nibble_to_ascii #(.UPPERCASE(1)) u_n2a_uc (.i_nibble(nib), .o_ascii(nib_uc));
    nibble_to_ascii #(.UPPERCASE(0)) u_n2a_lc (.i_nibble(nib), .o_ascii(nib_lc));

    int n_cmp  = 0;
    int n_fail = 0;
    int lf_cyc = -1;
    logic [7:0] exp_q [3][$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic push_line(input int id, input string s);
        for (int i = 0; i < s.len(); i++) exp_q[id].push_back(s[i]);
        exp_q[id].push_back(8'h0D);
        exp_q[id].push_back(8'h0A);
    endtask

    task automatic take_byte(input int id, input logic [7:0] got);
        logic [7:0] e;
        n_cmp++;
        if (exp_q[id].size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_byte dut%0d: got %02h, expected none", id, got);
        end else begin
            e = exp_q[id].pop_front();
            if (got !== e) begin
                n_fail++;
                $display("FAIL byte dut%0d: got %02h, expected %02h", id, got, e);
            end
        end
    endtask

    // Monitors: a character is taken whenever valid and the ready pulse coincide.
    always @(negedge clk) begin
        if (a_tx_valid && tx_ready) begin
            take_byte(0, a_tx_data);
            if (a_tx_data == 8'h0A) lf_cyc = cyc;
        end else if (tx_ready && a_rst_n) begin
            chk("idle_char_a", {24'd0, a_tx_data}, 32'h00);
        end
        if (b_tx_valid && tx_ready) take_byte(1, b_tx_data);
        if (c_tx_valid && tx_ready) take_byte(2, c_tx_data);
    end

    function automatic logic busy_of(input int id);
        case (id)
            0:       return a_busy;
            1:       return b_busy;
            default: return c_busy;
        endcase
    endfunction

    task automatic wait_done(input int id, input int budget);
        int k = 0;
        while (k < budget && (exp_q[id].size() != 0 || busy_of(id))) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("line_done_dut%0d", id),
            {31'd0, (exp_q[id].size() == 0 && !busy_of(id))}, 32'd1);
    endtask

    task automatic wait_qsize(input int id, input int sz, input int budget);
        int k = 0;
        while (k < budget && exp_q[id].size() > sz) begin
            @(negedge clk);
            k++;
        end
        chk("mid_line_reached", {31'd0, (exp_q[id].size() <= sz)}, 32'd1);
    endtask

    // One-cycle offer on DUT A, then scramble i_word to show it is not re-read.
    task automatic send_a(input logic [15:0] w, input logic [7:0] first);
        @(posedge clk); #1;
        a_valid = 1'b1; a_word = w;
        @(posedge clk); #1;
        a_valid = 1'b0; a_word = 16'h0000;
        chk("first_digit_valid", {31'd0, a_tx_valid}, 32'd1);
        chk("first_digit_data", {24'd0, a_tx_data}, {24'd0, first});
    endtask

    initial begin
        string hu, hl;
        int acc2;
        a_rst_n = 1'b0; bc_rst_n = 1'b0;
        a_valid = 1'b0; a_word = '0;
        b_valid = 1'b0; b_word = '0;
        c_valid = 1'b0; c_word = '0;
        nib = 4'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_tx_valid", {31'd0, a_tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, a_tx_data}, 32'h00);
        chk("rst_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
        chk("rst_in_ready_b", {31'd0, b_in_ready}, 32'd1);
        chk("rst_tx_valid_c", {31'd0, c_tx_valid}, 32'd0);
        @(negedge clk);
        a_rst_n = 1'b1; bc_rst_n = 1'b1;

        // Nibble converter unit test
        hu = "0123456789ABCDEF";
        hl = "0123456789abcdef";
        for (int v = 0; v < 16; v++) begin
            nib = v[3:0];
            #1;
            chk($sformatf("n2a_uc_%0d", v), {24'd0, nib_uc}, {24'd0, hu[v]});
            chk($sformatf("n2a_lc_%0d", v), {24'd0, nib_lc}, {24'd0, hl[v]});
        end

        // 1: 16-bit word
        push_line(0, "9F0D");
        send_a(16'h9F0D, "9");
        wait_done(0, 200);
        chk("t1_busy_low", {31'd0, a_busy}, 32'd0);

        // 2: 96-bit read-ID capture
        push_line(1, "9F0D5D52D200000000000000");
        @(posedge clk); #1;
        b_valid = 1'b1; b_word = 96'h9F0D_5D52_D200_0000_0000_0000;
        @(posedge clk); #1;
        b_valid = 1'b0; b_word = '1;
        chk("t2_first_digit", {24'd0, b_tx_data}, 32'h39);
        wait_done(1, 400);

        // 3: offer while busy is ignored
        push_line(0, "1357");
        send_a(16'h1357, "1");
        wait_qsize(0, 4, 100);
        @(posedge clk); #1;
        a_valid = 1'b1; a_word = 16'hFFFF;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            chk("t3_in_ready_low", {31'd0, a_in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        wait_done(0, 200);
        repeat (30) @(negedge clk);
        chk("t3_no_second_line", {31'd0, a_busy}, 32'd0);

        // 4: back-to-back, valid held high
        push_line(0, "1234");
        push_line(0, "ABCD");
        @(posedge clk); #1;
        a_valid = 1'b1; a_word = 16'h1234;
        begin
            int k = 0;
            @(negedge clk);
            while (!a_in_ready && k < 50) begin @(negedge clk); k++; end
        end
        @(posedge clk); #1;
        a_word = 16'hABCD;
        acc2 = -100;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (a_in_ready) begin acc2 = cyc; break; end
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        chk("t4_accept_after_lf", acc2, lf_cyc + 1);
        wait_done(0, 200);

        // 5: reset mid-line after two digits
        push_line(0, "5A5A");
        send_a(16'h5A5A, "5");
        wait_qsize(0, 4, 100);
        @(posedge clk); #3;
        a_rst_n = 1'b0;
        #1;
        chk("t5_rst_tx_valid", {31'd0, a_tx_valid}, 32'd0);
        chk("t5_rst_busy", {31'd0, a_busy}, 32'd0);
        chk("t5_rst_in_ready", {31'd0, a_in_ready}, 32'd1);
        chk("t5_rst_tx_data", {24'd0, a_tx_data}, 32'h00);
        exp_q[0].delete();
        @(negedge clk);
        a_rst_n = 1'b1;
        push_line(0, "C3E7");
        send_a(16'hC3E7, "C");
        wait_done(0, 200);

        // 6: 32-bit lowercase, grouped when the macro is defined
`ifdef HEX_DUMP_GROUP_EN
        push_line(2, "dead beef");
`else
        push_line(2, "deadbeef");
`endif
        @(posedge clk); #1;
        c_valid = 1'b1; c_word = 32'hDEADBEEF;
        @(posedge clk); #1;
        c_valid = 1'b0; c_word = 32'h0;
        chk("t6_first_digit", {24'd0, c_tx_data}, 32'h64);
        wait_done(2, 300);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_hex_dump_tx
`default_nettype wire
